// File: rtl/store_buffer_if.sv
// -----------------------------------------------------------------------------
// store_buffer_if
// Bundles the memory-stage request side and the data_mem port side of the
// store buffer.
//   master : memory stage / bench -- drives requests, observes stall, port, status
//   slave  : store_buffer         -- consumes requests, drives stall, port, status
// Signals:
//   iwr_valid, ird_valid, ifence, iaddr, iwdata, ibe  : requests
//   ostall                                            : hold the memory stage
//   omem_wen, omem_addr, omem_wdata, omem_be          : data_mem port
//   ocount, oempty, ofull                             : occupancy status
// -----------------------------------------------------------------------------
interface store_buffer_if #(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_ADDR_WIDTH = 32,
    parameter int MP_DEPTH      = 4
);
    localparam int CW = $clog2(MP_DEPTH + 1);

    logic                     iwr_valid;
    logic                     ird_valid;
    logic                     ifence;
    logic [MP_ADDR_WIDTH-1:0] iaddr;
    logic [MP_DATA_WIDTH-1:0] iwdata;
    logic [1:0]               ibe;

    logic                     ostall;
    logic                     omem_wen;
    logic [MP_ADDR_WIDTH-1:0] omem_addr;
    logic [MP_DATA_WIDTH-1:0] omem_wdata;
    logic [1:0]               omem_be;
    logic [CW-1:0]            ocount;
    logic                     oempty;
    logic                     ofull;

    modport master (
        output iwr_valid, ird_valid, ifence, iaddr, iwdata, ibe,
        input  ostall, omem_wen, omem_addr, omem_wdata, omem_be,
        input  ocount, oempty, ofull
    );

    modport slave (
        input  iwr_valid, ird_valid, ifence, iaddr, iwdata, ibe,
        output ostall, omem_wen, omem_addr, omem_wdata, omem_be,
        output ocount, oempty, ofull
    );
endinterface

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// Posted-write FIFO between the memory stage and data_mem. Stores enqueue in
// one cycle and drain in program order whenever the memory port is not taken
// by a load. A load whose word address matches any buffered store stalls and
// drains the head until the match is gone (no forwarding). A fence stalls
// until the buffer is empty.
// Ports:
//   iclk  : clock, rising edge
//   irst  : asynchronous active-low reset
//   bus   : store_buffer_if.slave (requests, data_mem port, status)
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_ADDR_WIDTH = 32,
    parameter int MP_DEPTH      = 4
) (
    input  logic          iclk,
    input  logic          irst,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(MP_DEPTH);
    localparam int CW = $clog2(MP_DEPTH + 1);
    localparam int AW = MP_ADDR_WIDTH;
    localparam int DW = MP_DATA_WIDTH;

    // Pointer and occupancy state
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Entry storage
    logic [AW-1:0] addr_q [MP_DEPTH];
    logic [DW-1:0] data_q [MP_DEPTH];
    logic [1:0]    be_q   [MP_DEPTH];

    logic nonempty;
    logic full;
    logic hit;
    logic drain;
    logic enq;
    logic load_port;

    assign nonempty = (count_q != '0);
    assign full     = (count_q == CW'(MP_DEPTH));

    // An entry is live when its distance from head is below count; the
    // subtraction wraps naturally because MP_DEPTH is a power of two.
    // NOTE: every variable assigned in always_comb gets a default before any
    // conditional logic, otherwise a path that skips it infers a latch.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < MP_DEPTH; i++) begin
            logic [PW-1:0] offset;
            offset = PW'(i) - head_q;
            if ((CW'(offset) < count_q) &&
                (addr_q[i][AW-1:2] == bus.iaddr[AW-1:2]))
                hit = 1'b1;
        end
        hit = hit & bus.ird_valid;
    end

    // The port goes to the load only when the load is not superseded by a
    // simultaneous store and nothing is draining.
    assign drain     = nonempty & (~bus.ird_valid | hit);
    assign enq       = bus.iwr_valid & (~full | drain);
    assign load_port = bus.ird_valid & ~bus.iwr_valid & ~drain;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) head_d = head_q + PW'(1);
        if (enq)   tail_d = tail_q + PW'(1);
        case ({enq, drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage has no reset; an entry is only observed once count
    // covers it, and count is reset.
    always_ff @(posedge iclk) begin
        if (enq) begin
            addr_q[tail_q] <= bus.iaddr;
            data_q[tail_q] <= bus.iwdata;
            be_q[tail_q]   <= bus.ibe;
        end
    end

    // Outputs are forced quiet while reset is held, whatever the inputs do.
    always_comb begin
        bus.ostall     = 1'b0;
        bus.omem_wen   = 1'b0;
        bus.omem_addr  = '0;
        bus.omem_wdata = '0;
        bus.omem_be    = 2'b00;
        if (irst) begin
            bus.ostall = (bus.iwr_valid & ~enq)
                       | (bus.ird_valid & ~bus.iwr_valid & hit)
                       | (bus.ifence & nonempty);
            if (drain) begin
                bus.omem_wen   = 1'b1;
                bus.omem_addr  = addr_q[head_q];
                bus.omem_wdata = data_q[head_q];
                bus.omem_be    = be_q[head_q];
            end else if (load_port) begin
                bus.omem_addr = bus.iaddr;
                bus.omem_be   = bus.ibe;
            end
        end
    end

    assign bus.ocount = count_q;
    assign bus.oempty = ~nonempty;
    assign bus.ofull  = full;

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
// Self-checking bench for store_buffer. A queue of pending stores is the
// reference: each cycle the expected stall, port and status values are worked
// out from the queue and the current request, then the queue is updated.
// -----------------------------------------------------------------------------
module tb_store_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  b;
    } ent_t;

    logic iclk;
    logic irst;
    int   checks;
    int   errors;
    ent_t q[$];
    logic [31:0] mem [logic [31:0]];
    logic        last_stall;

    store_buffer_if #(.MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(32), .MP_DEPTH(DEPTH)) bus ();

    store_buffer #(.MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(32), .MP_DEPTH(DEPTH)) dut (
        .iclk (iclk),
        .irst (irst),
        .bus  (bus.slave)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Behavioural data_mem: latches whatever the buffer writes.
    always @(posedge iclk) begin
        if (irst && bus.omem_wen) mem[bus.omem_addr] = bus.omem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive request, check at the falling edge, advance the model.
    task automatic step(input bit wr, input bit rd, input bit fc,
                        input logic [31:0] a, input logic [31:0] d, input logic [1:0] b);
        bit          mhit, mdrain, menq, mstall, mwen;
        logic [31:0] maddr, mdata;
        logic [1:0]  mbe;
        int          n;
        bus.iwr_valid = wr;
        bus.ird_valid = rd;
        bus.ifence    = fc;
        bus.iaddr     = a;
        bus.iwdata    = d;
        bus.ibe       = b;
        @(negedge iclk);
        n    = q.size();
        mhit = 1'b0;
        if (rd) foreach (q[i]) if ((q[i].a >> 2) == (a >> 2)) mhit = 1'b1;
        mdrain = (n > 0) && (!rd || mhit);
        menq   = wr && ((n < DEPTH) || mdrain);
        mstall = (wr && !menq) || (rd && !wr && mhit) || (fc && n > 0);
        mwen = 1'b0; maddr = '0; mdata = '0; mbe = 2'b00;
        if (mdrain) begin
            mwen = 1'b1; maddr = q[0].a; mdata = q[0].d; mbe = q[0].b;
        end else if (rd && !wr) begin
            maddr = a; mbe = b;
        end
        check("ostall",     32'(bus.ostall),     32'(mstall));
        check("omem_wen",   32'(bus.omem_wen),   32'(mwen));
        check("omem_addr",  bus.omem_addr,       maddr);
        check("omem_wdata", bus.omem_wdata,      mdata);
        check("omem_be",    32'(bus.omem_be),    32'(mbe));
        check("ocount",     32'(bus.ocount),     32'(n));
        check("oempty",     32'(bus.oempty),     32'(n == 0));
        check("ofull",      32'(bus.ofull),      32'(n == DEPTH));
        last_stall = bus.ostall;
        @(posedge iclk);
        if (mdrain) void'(q.pop_front());
        if (menq) q.push_back('{a: a, d: d, b: b});
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 32'h0, 32'h0, 2'b00);
    endtask

    initial begin
        int peak;
        int stalls;
        checks = 0;
        errors = 0;
        bus.iwr_valid = 0; bus.ird_valid = 0; bus.ifence = 0;
        bus.iaddr = '0; bus.iwdata = '0; bus.ibe = '0;
        irst = 1'b0;
        #12;
        // Reset state, with a store and load pending on the inputs.
        bus.iwr_valid = 1; bus.ird_valid = 1; bus.iaddr = 32'h44;
        #1;
        check("rst_ostall",  32'(bus.ostall),   32'd0);
        check("rst_wen",     32'(bus.omem_wen), 32'd0);
        check("rst_addr",    bus.omem_addr,     32'd0);
        check("rst_count",   32'(bus.ocount),   32'd0);
        check("rst_empty",   32'(bus.oempty),   32'd1);
        check("rst_full",    32'(bus.ofull),    32'd0);
        bus.iwr_valid = 0; bus.ird_valid = 0;
        @(posedge iclk); #1;
        irst = 1'b1;
        @(posedge iclk); #1;
        idle(2);

        // Back-to-back word stores, no loads: never stalls, occupancy peaks at 1.
        peak = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 32'h10 + 32'(4 * i), 32'hA000 + 32'(i), 2'b10);
            if (int'(bus.ocount) > peak) peak = int'(bus.ocount);
        end
        idle(2);
        check("b2b_peak", 32'(peak), 32'd1);
        for (int i = 0; i < 6; i++)
            check("b2b_mem", mem.exists(32'h10 + 32'(4 * i)) ? mem[32'h10 + 32'(4 * i)] : 32'hDEAD,
                  32'hA000 + 32'(i));

        // Fill under loads, then the 5th store stalls until a load-free cycle.
        for (int i = 0; i < 4; i++) step(1, 1, 0, 32'h200 + 32'(4 * i), 32'hB000 + 32'(i), 2'b10);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 32'h80, 32'h0, 2'b10);
        check("fill_full", 32'(bus.ofull), 32'd1);
        step(1, 1, 0, 32'h210, 32'hB004, 2'b10);
        check("fill_stall", 32'(last_stall), 32'd1);
        step(1, 1, 0, 32'h210, 32'hB004, 2'b10);
        step(1, 0, 0, 32'h210, 32'hB004, 2'b10);
        check("fill_go", 32'(last_stall), 32'd0);
        idle(6);

        // Load hit: two stall cycles, then the load reads the new word.
        step(1, 1, 0, 32'h40,  32'h11,       2'b00);
        step(1, 1, 0, 32'h100, 32'hCAFEF00D, 2'b10);
        step(1, 1, 0, 32'h44,  32'h2222,     2'b01);
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 32'h101, 32'h0, 2'b10);
            if (last_stall) stalls++;
        end
        check("hit_stalls", 32'(stalls), 32'd2);
        check("hit_mem", mem.exists(32'h100) ? mem[32'h100] : 32'hDEAD, 32'hCAFEF00D);
        idle(3);

        // Full with simultaneous enqueue and drain for 8 cycles.
        for (int i = 0; i < 4; i++) step(1, 1, 0, 32'h400 + 32'(4 * i), 32'hC000 + 32'(i), 2'b10);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 32'h480 + 32'(4 * i), 32'hD000 + 32'(i), 2'b10);
            check("wrap_nostall", 32'(last_stall), 32'd0);
        end
        idle(5);

        // Fence with three entries: exactly three stall cycles.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h600 + 32'(4 * i), 32'hE000 + 32'(i), 2'b10);
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 32'h0, 32'h0, 2'b00);
            if (!last_stall) break;
            stalls++;
        end
        check("fence_stalls", 32'(stalls), 32'd3);
        check("fence_empty",  32'(bus.oempty), 32'd1);

        // Reset mid-operation with three entries queued.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h700 + 32'(4 * i), 32'hF000 + 32'(i), 2'b10);
        bus.iwr_valid = 1; bus.ird_valid = 1; bus.iaddr = 32'h900;
        @(negedge iclk);
        irst = 1'b0;
        #1;
        check("mrst_count", 32'(bus.ocount),   32'd0);
        check("mrst_empty", 32'(bus.oempty),   32'd1);
        check("mrst_wen",   32'(bus.omem_wen), 32'd0);
        check("mrst_stall", 32'(bus.ostall),   32'd0);
        #2;
        irst = 1'b1;
        q.delete();
        bus.iwr_valid = 0; bus.ird_valid = 0;
        @(posedge iclk); #1;
        idle(3);
        check("mrst_nowrite", 32'(mem.exists(32'h700)), 32'd0);

        // Randomized traffic over a small address pool so hits are frequent.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = 32'h300 + 32'($urandom_range(0, 5) * 2);
            step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0,
                 a, $urandom, 2'($urandom_range(0, 2)));
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
